// File: rtl/softmax_row_max_sub_if.sv
// softmax_row_max_sub_if: score input stream and max-subtracted output stream with boundary flags
interface softmax_row_max_sub_if #(parameter int DATA_WIDTH = 8);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH:0]   out_data;
  logic signed [DATA_WIDTH-1:0] out_row_max;
  logic                         out_last;
  logic                         out_mat_last;
  logic                         out_frame_last;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row_max, out_last, out_mat_last, out_frame_last
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row_max, out_last, out_mat_last, out_frame_last
  );
endinterface

// File: rtl/softmax_row_max_sub.sv
// softmax_row_max_sub: buffers one score row, tracks its max, replays it as x - max with row/matrix/frame flags
module softmax_row_max_sub #(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_NUM = 12,
  parameter int ROW_NUM    = 128,
  parameter int ROW_LEN    = 128
) (
  input logic                    clk_p,
  input logic                    rst_n,
  softmax_row_max_sub_if.slave   bus
);
  localparam int CW = $clog2(ROW_LEN);
  localparam int RW = ROW_NUM > 1 ? $clog2(ROW_NUM) : 1;
  localparam int MW = MATRIX_NUM > 1 ? $clog2(MATRIX_NUM) : 1;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t                       state_q, state_d;
  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic [MW-1:0]                mat_q, mat_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic signed [DATA_WIDTH-1:0] buf_q [ROW_LEN];
  logic signed [DATA_WIDTH-1:0] buf_d [ROW_LEN];
  logic                         col_end, row_end, mat_end, in_hs, out_hs;
  assign col_end = col_q == CW'(ROW_LEN - 1);
  assign row_end = row_q == RW'(ROW_NUM - 1);
  assign mat_end = mat_q == MW'(MATRIX_NUM - 1);
  assign bus.in_ready       = state_q == FILL;
  assign bus.out_valid      = state_q == DRAIN;
  assign in_hs              = bus.in_ready & bus.in_valid;
  assign out_hs             = bus.out_valid & bus.out_ready;
  // both operands sign-extended by one bit so the difference (always <= 0) cannot overflow
  assign bus.out_data       = bus.out_valid ? {buf_q[col_q][DATA_WIDTH-1], buf_q[col_q]} - {max_q[DATA_WIDTH-1], max_q} : '0;
  assign bus.out_row_max    = max_q;
  assign bus.out_last       = bus.out_valid & col_end;
  assign bus.out_mat_last   = bus.out_last & row_end;
  assign bus.out_frame_last = bus.out_mat_last & mat_end;
  // next state: fill the row while tracking its max, then drain it and advance the row/matrix position
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    mat_d   = mat_q;
    max_d   = max_q;
    buf_d   = buf_q;
    if (state_q == IDLE) state_d = FILL;
    if (in_hs) begin
      buf_d[col_q] = bus.in_data;
      max_d        = (col_q == '0 || bus.in_data > max_q) ? bus.in_data : max_q;
      col_d        = col_end ? '0 : col_q + CW'(1);
      state_d      = col_end ? DRAIN : FILL;
    end
    if (out_hs) begin
      col_d   = col_end ? '0 : col_q + CW'(1);
      state_d = col_end ? FILL : DRAIN;
      row_d   = col_end ? (row_end ? '0 : row_q + RW'(1)) : row_q;
      mat_d   = col_end && row_end ? (mat_end ? '0 : mat_q + MW'(1)) : mat_q;
    end
  end
  // state registers; reset discards any partial row and rewinds to matrix 0, row 0
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      mat_q   <= '0;
      max_q   <= '0;
      buf_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mat_q   <= mat_d;
      max_q   <= max_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: tb/tb_softmax_row_max_sub.sv
// tb_softmax_row_max_sub: randomized handshake bench checked against a row-level reference model
module tb_softmax_row_max_sub;
  localparam int DW = 8, RL = 4, RN = 2, MN = 2;
  logic clk_p = 0;
  logic rst_n = 1;
  always #5 clk_p = ~clk_p;
  softmax_row_max_sub_if #(.DATA_WIDTH(DW)) ifc ();
  softmax_row_max_sub #(.DATA_WIDTH(DW), .MATRIX_NUM(MN), .ROW_NUM(RN), .ROW_LEN(RL)) dut (
    .clk_p(clk_p),
    .rst_n(rst_n),
    .bus  (ifc)
  );
  typedef struct {int data; int rmax; bit last; bit ml; bit fl;} exp_t;
  exp_t exp_q[$];
  int   in_q[$];
  int   cur_row[$];
  int   rows_done;
  int   checks = 0;
  int   errors = 0;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic push_row(input int a, input int b, input int c, input int d);
    in_q.push_back(a);
    in_q.push_back(b);
    in_q.push_back(c);
    in_q.push_back(d);
  endtask
  task automatic push_rand_rows(input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < RL; i++)
        in_q.push_back($urandom_range(3) == 0 ? ($urandom_range(1) ? 127 : -128) : int'($urandom_range(255)) - 128);
  endtask
  // a complete row yields RL expected words: x - max, the max, and the position flags of that row
  function automatic void model_accept(input int v);
    cur_row.push_back(v);
    if (cur_row.size() == RL) begin
      int m = cur_row[0];
      foreach (cur_row[i]) if (cur_row[i] > m) m = cur_row[i];
      for (int i = 0; i < RL; i++) begin
        exp_t e;
        e.data = cur_row[i] - m;
        e.rmax = m;
        e.last = (i == RL - 1);
        e.ml   = e.last && (rows_done % RN == RN - 1);
        e.fl   = e.ml && ((rows_done / RN) % MN == MN - 1);
        exp_q.push_back(e);
      end
      rows_done++;
      cur_row.delete();
    end
  endfunction
  task automatic do_reset();
    ifc.in_valid  = 0;
    ifc.out_ready = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data", int'(ifc.out_data), 0);
    check("rst_row_max", int'(ifc.out_row_max), 0);
    check("rst_flags", int'({ifc.out_last, ifc.out_mat_last, ifc.out_frame_last}), 0);
    exp_q.delete();
    in_q.delete();
    cur_row.delete();
    rows_done = 0;
    repeat (2) @(negedge clk_p);
    rst_n = 1;
    check("idle_rdy", ifc.in_ready, 0);
    @(negedge clk_p);
    check("first_rdy", ifc.in_ready, 1);
  endtask
  // drives both sides with the given percent probabilities until the queues drain or stop_outs outputs are taken
  task automatic run(input int pin, input int pout, input int stop_outs);
    int outs = 0;
    int cyc = 0;
    bit prev_stall = 0, prev_row_in = 0, prev_row_out = 0;
    int pd = 0, pm = 0, pf = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && (stop_outs < 0 || outs < stop_outs)) begin
      @(negedge clk_p);
      cyc++;
      if (cyc > 3000) begin
        check("timeout", cyc, 0);
        break;
      end
      check("excl", int'(ifc.in_ready & ifc.out_valid), 0);
      if (prev_row_in) check("latency", ifc.out_valid, 1);
      if (prev_row_out) check("rdy_back", ifc.in_ready, 1);
      if (prev_stall) begin
        check("stall_valid", ifc.out_valid, 1);
        check("stall_data", int'(ifc.out_data), pd);
        check("stall_max", int'(ifc.out_row_max), pm);
        check("stall_flags", int'({ifc.out_last, ifc.out_mat_last, ifc.out_frame_last}), pf);
      end
      ifc.in_valid  = in_q.size() > 0 && $urandom_range(99) < pin;
      ifc.in_data   = ifc.in_valid ? DW'(in_q[0]) : DW'($urandom);
      ifc.out_ready = $urandom_range(99) < pout;
      prev_row_in  = 0;
      prev_row_out = 0;
      if (ifc.in_valid && ifc.in_ready) begin
        model_accept(in_q.pop_front());
        prev_row_in = cur_row.size() == 0;
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          exp_t e = exp_q.pop_front();
          check("out_data", int'(ifc.out_data), e.data);
          check("out_row_max", int'(ifc.out_row_max), e.rmax);
          check("out_last", ifc.out_last, int'(e.last));
          check("out_mat_last", ifc.out_mat_last, int'(e.ml));
          check("out_frame_last", ifc.out_frame_last, int'(e.fl));
          prev_row_out = e.last;
        end
        outs++;
      end
      prev_stall = ifc.out_valid && !ifc.out_ready;
      pd = int'(ifc.out_data);
      pm = int'(ifc.out_row_max);
      pf = int'({ifc.out_last, ifc.out_mat_last, ifc.out_frame_last});
    end
    @(negedge clk_p);
    ifc.in_valid  = 0;
    ifc.out_ready = 0;
  endtask
  initial begin
    ifc.in_valid  = 0;
    ifc.in_data   = '0;
    ifc.out_ready = 0;
    do_reset();
    push_row(3, -5, 7, 0);
    run(100, 100, -1);
    push_row(-128, 127, -128, 0);
    push_row(-128, -128, -128, -128);
    push_row(5, 5, 5, 5);
    run(100, 100, -1);
    push_rand_rows(8);
    run(50, 50, -1);
    do_reset();
    push_rand_rows(9);
    run(100, 100, -1);
    do_reset();
    push_rand_rows(3);
    run(100, 100, 2 * RL + 2);
    do_reset();
    push_rand_rows(2);
    run(70, 70, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
